// File: rtl/fibo_req_arbiter.sv
// Round-robin arbiter in front of a single iterative Fibonacci engine.
// One request is in flight at a time; its result is held until the consumer accepts it.
module fibo_req_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int NW    = 5,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*NW-1:0] req_n,
   output logic [NREQ-1:0]    req_ready,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [WIDTH-1:0]   rsp_data,
   input  logic               rsp_ready,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      STEP = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_nextState;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [NW-1:0]    r_cnt;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   r_rrPtr;
   logic [WIDTH-1:0] r_rspData;
   logic [IDW-1:0]   r_rspId;

   logic             w_anyReq;
   logic [IDW-1:0]   w_grantId;
   logic [NW-1:0]    w_grantN;
   logic             w_accept;
   logic             w_rspFire;
   logic [WIDTH-1:0] w_sum;
   logic [IDW-1:0]   w_nextPtr;
   int               w_idx;

   // Search upward from the round-robin pointer with wrap-around; first hit wins.
   always_comb begin
      w_anyReq  = 1'b0;
      w_grantId = '0;
      w_idx     = 0;
      for (int off = 0; off < NREQ; off++) begin
         w_idx = int'(r_rrPtr) + off;
         if (w_idx >= NREQ) begin
            w_idx = w_idx - NREQ;
         end
         if (!w_anyReq && req_valid[w_idx]) begin
            w_anyReq  = 1'b1;
            w_grantId = IDW'(w_idx);
         end
      end
   end

   assign w_grantN  = req_n[int'(w_grantId)*NW +: NW];
   assign w_sum     = r_a + r_b;
   assign w_nextPtr = (r_id == IDW'(NREQ-1)) ? '0 : r_id + IDW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The grant strobe is combinational in IDLE so a waiting request transfers in that cycle.
   always_comb begin
      w_nextState = r_state;
      req_ready   = '0;
      w_accept    = 1'b0;
      w_rspFire   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               req_ready[w_grantId] = 1'b1;
               w_accept             = 1'b1;
               w_nextState          = LOAD;
            end
         end
         LOAD: begin
            w_nextState = (r_cnt == '0) ? RESP : STEP;
         end
         STEP: begin
            if (r_cnt == NW'(1)) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_rspFire   = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Result registers are loaded on entry to RESP so they survive the handshake and the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= WIDTH'(1);
         r_cnt     <= '0;
         r_id      <= '0;
         r_rrPtr   <= '0;
         r_rspData <= '0;
         r_rspId   <= '0;
      end else begin
         if (w_accept) begin
            r_id  <= w_grantId;
            r_cnt <= w_grantN;
            r_a   <= '0;
            r_b   <= WIDTH'(1);
         end
         if (r_state == LOAD && r_cnt == '0) begin
            r_rspData <= r_a;
            r_rspId   <= r_id;
         end
         if (r_state == STEP) begin
            r_a   <= r_b;
            r_b   <= w_sum;
            r_cnt <= r_cnt - NW'(1);
            if (r_cnt == NW'(1)) begin
               r_rspData <= r_b;
               r_rspId   <= r_id;
            end
         end
         if (w_rspFire) begin
            r_rrPtr <= w_nextPtr;
         end
      end
   end

   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_rspData;
   assign rsp_id    = r_rspId;
   assign busy      = (r_state != IDLE);

endmodule
